// File: rtl/common_pkg.sv
// Shared types and constants for the systolic array datapath and its result drain.
package common_pkg;

   localparam int SYS_ARRAY_SIZE = 4;

   typedef logic [15:0] data_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPTURE,
      DRAIN
   } drain_state_e;

   localparam int DRAIN_LAT_DEFAULT = 2 * SYS_ARRAY_SIZE;

   // Counter width that stays at least one bit wide for degenerate ranges.
   function automatic int idx_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Array-side and host-side signals of the result drain.
// The master modport is the drain itself; the slave modport is its environment.
interface systolic_result_drain_if
   import common_pkg::*;
   #(parameter int N = SYS_ARRAY_SIZE) ();

   localparam int IW = idx_width(N);

   logic              last_i;
   data_t [N-1:0]     c_i;
   data_t [N-1:0]     row_o;
   logic  [IW-1:0]    row_idx_o;
   logic              row_last_o;
   logic              row_valid_o;
   logic              row_ready_i;
   logic              busy_o;
   logic              overflow_o;

   modport master (
      input  last_i, c_i, row_ready_i,
      output row_o, row_idx_o, row_last_o, row_valid_o, busy_o, overflow_o
   );

   modport slave (
      output last_i, c_i, row_ready_i,
      input  row_o, row_idx_o, row_last_o, row_valid_o, busy_o, overflow_o
   );

endinterface

// File: rtl/systolic_result_drain_buf.sv
// N x N result buffer: deskews the array wavefront while capturing and
// exposes one row at a time through an index-selected read port.
module result_deskew_buf
   import common_pkg::*;
#(
   parameter int N  = SYS_ARRAY_SIZE,
   parameter int KW = idx_width(2 * SYS_ARRAY_SIZE - 1),
   parameter int IW = idx_width(SYS_ARRAY_SIZE)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cap_en,
   input  logic [KW-1:0]        k,
   input  data_t [N-1:0]        c_i,
   input  logic [IW-1:0]        rd_idx,
   output data_t [N-1:0]        rd_row
);

   data_t [N-1:0][N-1:0] mem_q;

   // Column j lags by j cycles, so at capture step k it carries row k-j.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_q <= '0;
      end else if (cap_en) begin
         for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
               if (int'(k) == r + j) begin
                  mem_q[r][j] <= c_i[j];
               end
            end
         end
      end
   end

   assign rd_row = mem_q[rd_idx];

endmodule

// File: rtl/systolic_result_drain.sv
// Waits out the array pipeline after a product's last beat, captures the
// skewed result wavefront and streams it to the host one row per handshake.
module systolic_result_drain
   import common_pkg::*;
#(
   parameter int N   = SYS_ARRAY_SIZE,
   parameter int LAT = DRAIN_LAT_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   systolic_result_drain_if.master   bus
);

   localparam int IW = idx_width(N);
   localparam int KW = idx_width(2 * N - 1);
   localparam int WW = idx_width(LAT);

   localparam logic [KW-1:0] K_LAST   = KW'(2 * N - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   localparam logic [WW-1:0] W_LOAD   = WW'((LAT > 0) ? LAT - 1 : 0);

   drain_state_e    state_q;
   logic [WW-1:0]   wcnt_q;
   logic [KW-1:0]   k_q;
   logic [IW-1:0]   idx_q;
   logic            valid_q;
   logic            last_q;
   logic            busy_q;
   logic            ovf_q;
   data_t [N-1:0]   rd_row;

   result_deskew_buf #(
      .N  (N),
      .KW (KW),
      .IW (IW)
   ) u_buf (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cap_en (state_q == CAPTURE),
      .k      (k_q),
      .c_i    (bus.c_i),
      .rd_idx (idx_q),
      .rd_row (rd_row)
   );

   // Sequencer; a last strobe seen outside IDLE only raises the sticky
   // overflow flag and never restarts the sequence.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         k_q     <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.last_i && state_q != IDLE) begin
            ovf_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (bus.last_i) begin
                  busy_q <= 1'b1;
                  k_q    <= '0;
                  if (LAT == 0) begin
                     state_q <= CAPTURE;
                  end else begin
                     state_q <= WAIT;
                     wcnt_q  <= W_LOAD;
                  end
               end
            end
            WAIT: begin
               if (wcnt_q == '0) begin
                  state_q <= CAPTURE;
               end else begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            CAPTURE: begin
               if (k_q == K_LAST) begin
                  state_q <= DRAIN;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (N == 1);
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DRAIN: begin
               if (bus.row_ready_i) begin
                  if (idx_q == IDX_LAST) begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     idx_q  <= idx_q + 1'b1;
                     last_q <= (idx_q + 1'b1 == IDX_LAST);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.row_o       = valid_q ? rd_row : '0;
   assign bus.row_idx_o   = idx_q;
   assign bus.row_last_o  = last_q;
   assign bus.row_valid_o = valid_q;
   assign bus.busy_o      = busy_q;
   assign bus.overflow_o  = ovf_q;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Sits on the output side of systolic_array_wrap. The feeder drives a/b/last_i into the array; this block consumes the array's c vector.
- After a matrix product completes (last_i pulse), it waits a fixed pipeline latency, captures the skewed output wavefront into an N×N buffer, deskewing it as it goes.
- It then streams the result matrix out one row per handshake on a valid/ready interface toward the host/writeback side.

Parameters:
- N, default SYS_ARRAY_SIZE (common_pkg): array dimension = rows and columns of the result.
- LAT, default 2*SYS_ARRAY_SIZE: cycles from the accepted last_i to the first capture cycle. 0 is legal.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- last_i  in  1  same last strobe that is fed to the array; marks the final operand beat of a product.
- c_i  in  data_t[N-1:0]  array output vector; column j is valid skewed by j cycles.
- row_o  out  data_t[N-1:0]  deskewed result row.
- row_idx_o  out  $clog2(N)  index of the row currently presented.
- row_last_o  out  1  high with row N-1.
- row_valid_o  out  1  row_o, row_idx_o and row_last_o are valid.
- row_ready_i  in  1  downstream accepts the row.
- busy_o  out  1  high in any state other than IDLE.
- overflow_o  out  1  sticky; a last_i arrived while not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; all counters and the buffer are cleared to 0.
  - All outputs are 0.
- FSM states: IDLE, WAIT, CAPTURE, DRAIN.
- IDLE:
  - last_i=1 at cycle t goes to WAIT, loading wcnt=LAT-1.
  - If LAT==0, it goes directly to CAPTURE with k=0.
- WAIT:
  - wcnt decrements each cycle.
  - When wcnt==0, go to CAPTURE with k=0 on the next cycle, so capture k=0 occurs at cycle t+1+LAT.
- CAPTURE:
  - k runs 0..2N-2.
  - At each k, for every column j with 0<=k-j<N: buf[k-j][j] <= c_i[j]. Other entries are unchanged.
  - After k==2N-2, go to DRAIN with idx=0.
- DRAIN:
  - row_valid_o=1, row_o=buf[idx], row_idx_o=idx, row_last_o=(idx==N-1).
  - Outputs are registered/held stable while row_ready_i=0; no combinational path from row_ready_i to row_valid_o.
  - On a valid&&ready handshake, idx++.
  - A handshake at idx==N-1 returns to IDLE; row_valid_o is 0 the next cycle.
- last_i outside IDLE:
  - Ignored for sequencing; sets overflow_o=1, which is cleared only by reset.
  - This includes the cycle of the final DRAIN handshake, so back-to-back products need at least one IDLE cycle.
- busy_o = (state != IDLE), registered with the state.
- Data width: c_i is passed through unmodified (data_t); no arithmetic.
- idx and k use widths sized so they never wrap inside a legal range. For N=1, idx is 1 bit wide and CAPTURE lasts 1 cycle.
- Reset mid-operation (any state) aborts immediately:
  - Buffer contents are discarded.
  - row_valid_o drops asynchronously.
  - No partial row is emitted after release.

Decomposition:
- common_pkg already provides data_t and SYS_ARRAY_SIZE.
- Add to common_pkg: drain_state_e (IDLE/WAIT/CAPTURE/DRAIN) and localparam DRAIN_LAT_DEFAULT = 2*SYS_ARRAY_SIZE.
- One sub-module is natural: result_deskew_buf, the N×N register array with capture index k and write enable. Its read port is selected by idx.
- The FSM, counters and handshake logic stay in the top module.

Test Plan:
Settings: N=4, LAT=8, data_t 16-bit.
1. Basic product:
   - Stimulus: last_i pulse at cycle 10; from cycle 19 drive c_i[j] = 16*(k-j)+j whenever the entry is in range.
   - Response: four rows with row r = {r*16+0, r*16+1, r*16+2, r*16+3}; row_idx_o 0..3; row_last_o only on idx 3; busy_o high from cycle 11 until after the last handshake.
2. Backpressure:
   - Stimulus: same as test 1, with row_ready_i low for 5 cycles on row 1, then toggling 1/0.
   - Response: row_o and row_idx_o stable while stalled; exactly 4 handshakes; row 1 = {16,17,18,19}.
3. Overflow:
   - Stimulus: second last_i during CAPTURE, and another on the final DRAIN handshake cycle.
   - Response: overflow_o=1 and stays 1; no second capture; the FSM returns to IDLE after 4 rows.
4. LAT=0:
   - Stimulus: last_i at cycle t.
   - Response: capture k=0 occurs at cycle t+1; output rows are correct.
5. Reset mid-DRAIN:
   - Stimulus: assert rst_i low after row 1 is accepted.
   - Response: row_valid_o, busy_o and overflow_o are 0 immediately. After release and a new product with c_i=0xFFFF everywhere, all rows are 0xFFFF and none are stale.
6. Back-to-back:
   - Stimulus: two products with a one-cycle IDLE gap.
   - Response: 8 rows total, the second set matching the second stimulus; overflow_o stays 0.
